arb8_ctrl: RTL and testbench
============================

# arb8_ctrl

Sequential arbiter sharing one downstream resource among 8 requesters. Selection is priority-encoded: index 7 has top priority, or priority rotates round-robin when compiled in. The block holds a one-hot grant until the owner signals completion or a hold-timeout expires. It sits between the 8 request sources and the shared datapath, and drives the resource's select and valid.

## Interface
- `MAX_HOLD`, default 16: maximum granted cycles per ownership, legal range 1..255.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req`, input, 8: request vector, bit i is requester i.
- `done`, input, 1: single-cycle pulse from the current owner releasing the resource.
- `grant`, output, 8: registered one-hot grant; all zero when idle.
- `grant_id`, output, 3: registered binary index of the owner; 3'b000 when idle.
- `grant_valid`, output, 1: registered; high while any grant is asserted.
- `timeout`, output, 1: registered single-cycle pulse when an ownership is revoked by the hold limit.

## Operation
- FSM has two states, IDLE and BUSY. Reset state is IDLE.
- Reset values: grant=8'h00, grant_id=3'b000, grant_valid=0, timeout=0, hold counter=0, last_id=3'd0.
- IDLE with req==0: stay in IDLE, outputs stay zero.
- IDLE with req!=0: the encoder selects winner w. At the next edge: grant=1<<w, grant_id=w, grant_valid=1, last_id=w, counter=1, state becomes BUSY.
- BUSY, done=1: the next edge drops grant, grant_id and grant_valid to zero and returns to IDLE. timeout stays 0.
- BUSY, done=0, counter==MAX_HOLD: the next edge drops the grant, pulses timeout=1 for one cycle and returns to IDLE.
- BUSY otherwise: counter increments by 1 (8-bit counter, saturating at MAX_HOLD) and the grant is held.
- A drop of the owner's req bit while BUSY does not revoke the grant; only done or the hold limit releases it.
- done and the hold limit in the same cycle: done wins, no timeout pulse.
- done while IDLE is ignored. req changes while BUSY are not sampled.
- After a release there is always one IDLE cycle with grant_valid=0 before the next grant.
- Selection with fixed priority: the highest set index of req wins.

## Timing
- Latency from req to grant: 1 edge. req set in IDLE during cycle N gives the grant visible in cycle N+1.
- Release: done sampled at edge N gives grant low from N+1 and the earliest new grant at N+2.
- Maximum ownership: exactly MAX_HOLD cycles with grant_valid high. timeout is high in the first cycle after the last granted cycle.
- All outputs are registered; there is no combinational path from req or done to any output.
- Asserting rst_n low mid-ownership forces the reset values immediately (asynchronous) and discards the ownership. The first grant after reset follows the reset priority.

## Configuration
- Macro `ARB_ROUND_ROBIN_EN`.
- Defined: rotating priority. The search starts at last_id-1 and descends with 3-bit wrap (0-1 = 7) down to last_id, so the previous winner has lowest priority.
  - Reset last_id=0 makes the first search order 7,6,...,0, identical to fixed priority.
  - last_id updates only on a new grant.
- Undefined: fixed priority, highest index wins. last_id is still reset and updated but does not affect selection.

## Structure
- Package `arb8_pkg` holds:
  - the state enum (IDLE, BUSY);
  - constants N_REQ=8 and ID_W=3;
  - the reset value of last_id.
- Sub-module `prio_enc8`: purely combinational.
  - Inputs: an 8-bit vector. Outputs: a 3-bit highest-set index and a valid flag.
  - In round-robin mode, two instances handle the masked request (bits below last_id) and the unmasked request.
  - The masked winner is used if it is valid, otherwise the unmasked winner.
- Top level holds the FSM, hold counter, last_id and output registers.

## Test plan
- Reset: with rst_n=0 and req=8'hFF, all outputs are zero. Release reset with req=8'h81: grant=8'h80 and grant_id=7 after 1 edge.
- Release: owner 7 pulses done. grant=0 and grant_valid=0 for 1 cycle, then req=8'h01 gives grant=8'h01.
- Timeout: MAX_HOLD=4, req=8'h10, no done. grant_valid stays high for 4 cycles, then timeout pulses once and grant drops.
- Simultaneous: done asserted in the 4th granted cycle with MAX_HOLD=4. Normal release, timeout stays 0.
- Round-robin (ARB_ROUND_ROBIN_EN): req=8'hFF held, done pulsed each ownership. Grant order is 7,6,5,...,0,7. Without the macro, the order is 7 every time.
- Reset mid-ownership: rst_n low during BUSY. All outputs are zero immediately, and the next grant follows the reset priority.

Source files
------------

// File: rtl/arb8_pkg.sv
// Shared types and constants for the 8-way hold-limited arbiter.
package arb8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [ID_W-1:0] LAST_ID_RST = '0;

endpackage

// File: rtl/arb8_ctrl_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arb8_ctrl_if;
  import arb8_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, grant_valid, timeout
  );

endinterface

// File: rtl/prio_enc8.sv
// Combinational priority encoder: index of the highest set bit plus a valid flag.
module prio_enc8
  import arb8_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [ID_W-1:0]  idx_c,
  output logic             vld_c
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_c = '0;
    vld_c = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        idx_c = ID_W'(i);
        vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb8_ctrl.sv
// 8-requester arbiter with one-hot grant held until done or MAX_HOLD cycles.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise index 7 always wins.
module arb8_ctrl
  import arb8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)(
  input  logic        clk,
  input  logic        rst_n,
  arb8_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = 8;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;

  logic [ID_W-1:0]  win_id;
  logic             win_vld;

`ifdef ARB_ROUND_ROBIN_EN
  // Requests below last_id get first pick, so the previous winner ranks last.
  logic [N_REQ-1:0] req_masked;
  logic [ID_W-1:0]  m_id, u_id;
  logic             m_vld, u_vld;

  assign req_masked = bus.req & ((N_REQ'(1) << last_id_q) - N_REQ'(1));

  prio_enc8 u_enc_masked (
    .vec   (req_masked),
    .idx_c (m_id),
    .vld_c (m_vld)
  );

  prio_enc8 u_enc_full (
    .vec   (bus.req),
    .idx_c (u_id),
    .vld_c (u_vld)
  );

  assign win_id  = m_vld ? m_id : u_id;
  assign win_vld = m_vld | u_vld;
`else
  prio_enc8 u_enc (
    .vec   (bus.req),
    .idx_c (win_id),
    .vld_c (win_vld)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_id_q     <= LAST_ID_RST;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_id_q     <= last_id_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_id_d     = last_id_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d         = BUSY;
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          grant_id_d      = win_id;
          grant_valid_d   = 1'b1;
          last_id_d       = win_id;
          cnt_d           = CNT_W'(1);
        end
      end
      BUSY: begin
        // done has precedence over the hold limit.
        if (bus.done || (cnt_q == CNT_W'(MAX_HOLD))) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          cnt_d         = '0;
          timeout_d     = ~bus.done;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_arb8_ctrl.sv
// Scoreboard bench for arb8_ctrl: directed scenarios plus random req/done traffic.
module tb_arb8_ctrl;

  localparam int unsigned MAXH = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] id;
    logic       valid;
    logic       tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  arb8_ctrl_if bus ();

  arb8_ctrl #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: current owner (-1 when idle), cycles owned, last winner.
  int m_owner, m_held, m_last;
  bit m_tmo;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (m_last - k + 8) % 8;
      if (r[i]) return i;
    end
`else
    for (int i = 7; i >= 0; i--) if (r[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 0;
    m_tmo   = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    m_tmo = 0;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        m_owner = pick(r);
        m_held  = 1;
        m_last  = m_owner;
      end
    end else if (d) begin
      m_owner = -1;
    end else if (m_held == int'(MAXH)) begin
      m_owner = -1;
      m_tmo   = 1;
    end else begin
      m_held++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [7:0] one;
    one     = 8'h01;
    e.grant = (m_owner >= 0) ? (one << m_owner) : 8'h00;
    e.id    = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.valid = (m_owner >= 0);
    e.tmo   = m_tmo;
    return e;
  endfunction

  // Drive inputs for this cycle and queue the outputs expected after the next edge.
  task automatic apply(input logic [7:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    model_step(r, d);
    exp_q.push_back(model_out());
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    @(negedge clk);
    apply(r, d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, bus.grant, 8'h00);
    check({tag, "_id"},    8'(bus.grant_id), 8'h00);
    check({tag, "_valid"}, 8'(bus.grant_valid), 8'h00);
    check({tag, "_tmo"},   8'(bus.timeout), 8'h00);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("grant",       bus.grant,              mon_e.grant);
      check("grant_id",    8'(bus.grant_id),       8'(mon_e.id));
      check("grant_valid", 8'(bus.grant_valid),    8'(mon_e.valid));
      check("timeout",     8'(bus.timeout),        8'(mon_e.tmo));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");

    // Reset release: first grant by reset priority.
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h81, 1'b0);
    step(8'h81, 1'b0);
    step(8'h00, 1'b1);
    step(8'h01, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);          // done while idle is ignored

    // Hold limit with no done.
    step(8'h10, 1'b0);
    repeat (4) step(8'h10, 1'b0);
    step(8'h00, 1'b0);

    // done coinciding with the hold limit.
    step(8'h10, 1'b0);
    repeat (3) step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // Owner drops req: grant held, later requester waits.
    step(8'h04, 1'b0);
    step(8'h02, 1'b0);
    step(8'h02, 1'b1);
    step(8'h02, 1'b0);
    step(8'h00, 1'b1);

    // Reset in the middle of an ownership.
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1 check_zero("inrst");

    // Release with all requesting, then rotate through owners.
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'hFF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(8'hFF, 1'b1);
      step(8'hFF, 1'b0);
    end
    step(8'h00, 1'b1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step(r, ($urandom_range(0, 4) == 0));
    end
    step(8'h00, 1'b0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
